// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences IF/ID/EX/MEM/WB and
// drives datapath strobes, mux selects and the ALUOp class for the ALU control unit.
`timescale 1ns/1ps
module multicycle_control_fsm (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       bcond,
   input  logic       mem_ready,
   input  logic       halt_req,
   output logic       mem_read,
   output logic       mem_write,
   output logic       i_or_d,
   output logic       ir_write,
   output logic       alu_out_write,
   output logic       reg_write,
   output logic       pc_write,
   output logic       pc_source,
   output logic       wb_sel,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [6:0] alu_op,
   output logic       is_halted
);

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;
   // The LOAD class decodes to a plain add in the ALU control unit.
   localparam logic [6:0] ALU_ADD      = OP_LOAD;

   localparam logic [1:0] B_RS2  = 2'b00;
   localparam logic [1:0] B_FOUR = 2'b01;
   localparam logic [1:0] B_IMM  = 2'b10;

   typedef enum logic [2:0] {
      S_IF, S_ID, S_EX, S_MEM, S_WB_ALU, S_WB_MEM, S_BR_TAKEN, S_HALT
   } state_t;

   state_t state_q, state_d;
   logic   is_halted_q, is_halted_d;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q     <= S_IF;
         is_halted_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         is_halted_q <= is_halted_d;
      end
   end

   assign is_halted_d = is_halted_q | (state_d == S_HALT);
   assign is_halted   = is_halted_q;

   always_comb begin
      // NOTE: every output gets a default before the case so no path can
      // leave a signal unassigned and infer a latch.
      state_d       = state_q;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_or_d        = 1'b0;
      ir_write      = 1'b0;
      alu_out_write = 1'b0;
      reg_write     = 1'b0;
      pc_write      = 1'b0;
      pc_source     = 1'b0;
      wb_sel        = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = B_RS2;
      alu_op        = ALU_ADD;

      case (state_q)
         S_IF: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_d  = S_ID;
            end
         end
         S_ID: begin
            alu_src_b     = B_FOUR;
            alu_out_write = 1'b1;
            if (opcode == OP_ECALL) begin
               if (halt_req) begin
                  state_d = S_HALT;
               end else begin
                  pc_write = 1'b1;
                  state_d  = S_IF;
               end
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            alu_op    = opcode;
            alu_src_a = 1'b1;
            alu_src_b = (opcode == OP_ARITH || opcode == OP_BRANCH) ? B_RS2 : B_IMM;
            case (opcode)
               OP_ARITH, OP_ARITH_IMM: begin
                  alu_out_write = 1'b1;
                  state_d       = S_WB_ALU;
               end
               OP_LOAD, OP_STORE: begin
                  alu_out_write = 1'b1;
                  state_d       = S_MEM;
               end
               OP_BRANCH: begin
                  if (bcond) begin
                     state_d = S_BR_TAKEN;
                  end else begin
                     pc_write  = 1'b1;
                     pc_source = 1'b1;
                     state_d   = S_IF;
                  end
               end
               OP_JAL, OP_JALR: begin
                  // Link value PC+4 was latched into ALUOut during ID.
                  if (opcode == OP_JAL) begin
                     alu_src_a = 1'b0;
                     alu_op    = ALU_ADD;
                  end
                  reg_write = 1'b1;
                  pc_write  = 1'b1;
                  state_d   = S_IF;
               end
               default: begin
                  pc_write  = 1'b1;
                  pc_source = 1'b1;
                  state_d   = S_IF;
               end
            endcase
         end
         S_MEM: begin
            i_or_d    = 1'b1;
            alu_src_b = B_FOUR;
            if (opcode == OP_LOAD) begin
               mem_read = 1'b1;
            end else begin
               mem_write = 1'b1;
            end
            if (mem_ready) begin
               if (opcode == OP_LOAD) begin
                  state_d = S_WB_MEM;
               end else begin
                  pc_write = 1'b1;
                  state_d  = S_IF;
               end
            end
         end
         S_WB_ALU, S_WB_MEM: begin
            reg_write = 1'b1;
            wb_sel    = (state_q == S_WB_MEM);
            alu_src_b = B_FOUR;
            pc_write  = 1'b1;
            state_d   = S_IF;
         end
         S_BR_TAKEN: begin
            alu_src_b = B_IMM;
            pc_write  = 1'b1;
            state_d   = S_IF;
         end
         S_HALT: begin
         end
         default: state_d = S_IF;
      endcase

      // An instruction interrupted by reset must not leave any architectural write behind.
      if (reset) begin
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         alu_out_write = 1'b0;
         reg_write     = 1'b0;
         pc_write      = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm: a driver pushes the expected
// per-cycle control word derived from the instruction's phase list; a monitor compares.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

   localparam logic [6:0] ARITH     = 7'b0110011;
   localparam logic [6:0] ARITH_IMM = 7'b0010011;
   localparam logic [6:0] LOAD      = 7'b0000011;
   localparam logic [6:0] STORE     = 7'b0100011;
   localparam logic [6:0] BRANCH    = 7'b1100011;
   localparam logic [6:0] JAL       = 7'b1101111;
   localparam logic [6:0] JALR      = 7'b1100111;
   localparam logic [6:0] ECALL     = 7'b1110011;
   localparam logic [6:0] UNKNOWN   = 7'b0001111;
   localparam logic [6:0] ADD       = LOAD;

   typedef struct packed {
      logic       mem_read, mem_write, i_or_d, ir_write, alu_out_write;
      logic       reg_write, pc_write, pc_source, wb_sel, alu_src_a;
      logic [1:0] alu_src_b;
      logic [6:0] alu_op;
      logic       is_halted;
   } outs_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = '0;
   logic       bcond = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
   logic       mem_read, mem_write, i_or_d, ir_write, alu_out_write, reg_write, pc_write;
   logic       pc_source, wb_sel, alu_src_a, is_halted;
   logic [1:0] alu_src_b;
   logic [6:0] alu_op;

   multicycle_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .mem_ready(mem_ready),
      .halt_req(halt_req), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
      .ir_write(ir_write), .alu_out_write(alu_out_write), .reg_write(reg_write),
      .pc_write(pc_write), .pc_source(pc_source), .wb_sel(wb_sel), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .is_halted(is_halted)
   );

   always #5 clk = ~clk;

   outs_t exp_q[$];
   outs_t msk_q[$];
   int    n_checks = 0;
   int    n_fail = 0;
   int    exp_retire = 0;
   int    act_retire = 0;
   int    cyc = 0;
   outs_t full_m, strobe_m;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic outs_t dflt();
      outs_t o = '0;
      o.alu_op = ADD;
      return o;
   endfunction

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One clock cycle of stimulus plus the control word the DUT must present in it.
   task automatic step(input logic rst, input logic mr, input logic bc, input logic hr,
                       input logic [6:0] op, input outs_t e, input outs_t m);
      @(posedge clk);
      #1;
      reset = rst; mem_ready = mr; bcond = bc; halt_req = hr; opcode = op;
      exp_q.push_back(e);
      msk_q.push_back(m);
      if (!rst && e.pc_write) exp_retire++;
   endtask

   task automatic reset_cycle(input logic [6:0] op);
      step(1'b1, rb(), rb(), rb(), op, dflt(), strobe_m);
   endtask

   // Walks one instruction through its phases as the control sequence defines them.
   task automatic run_instr(input logic [6:0] op, input bit bc, input bit hr,
                            input int if_wait, input int mem_wait, input bit rst_in_mem);
      outs_t e;
      repeat (if_wait) begin
         e = dflt(); e.mem_read = 1;
         step(0, 0, rb(), rb(), 7'($urandom), e, full_m);
      end
      e = dflt(); e.mem_read = 1; e.ir_write = 1;
      step(0, 1, rb(), rb(), 7'($urandom), e, full_m);

      // Decode: ALUOut <= PC + 4
      e = dflt(); e.alu_src_b = 2'b01; e.alu_out_write = 1;
      if (op == ECALL) begin
         if (hr) begin
            step(0, rb(), rb(), 1, op, e, full_m);
            repeat (10) begin
               e = dflt(); e.is_halted = 1;
               step(0, rb(), rb(), rb(), 7'($urandom), e, full_m);
            end
            reset_cycle(op);
         end else begin
            e.pc_write = 1;
            step(0, rb(), rb(), 0, op, e, full_m);
         end
         return;
      end
      step(0, rb(), rb(), rb(), op, e, full_m);

      // Execute
      e = dflt(); e.alu_op = op; e.alu_src_a = 1;
      e.alu_src_b = (op == ARITH || op == BRANCH) ? 2'b00 : 2'b10;
      if (op == ARITH || op == ARITH_IMM || op == LOAD || op == STORE) begin
         e.alu_out_write = 1;
      end else if (op == BRANCH) begin
         if (!bc) begin e.pc_write = 1; e.pc_source = 1; end
      end else if (op == JAL || op == JALR) begin
         e.reg_write = 1; e.pc_write = 1;
         if (op == JAL) begin e.alu_src_a = 0; e.alu_op = ADD; end
      end else begin
         e.pc_write = 1; e.pc_source = 1;
      end
      step(0, rb(), (op == BRANCH) ? bc : rb(), rb(), op, e, full_m);

      if (op == ARITH || op == ARITH_IMM) begin
         e = dflt(); e.reg_write = 1; e.alu_src_b = 2'b01; e.pc_write = 1;
         step(0, rb(), rb(), rb(), op, e, full_m);
      end else if (op == BRANCH && bc) begin
         e = dflt(); e.alu_src_b = 2'b10; e.pc_write = 1;
         step(0, rb(), rb(), rb(), op, e, full_m);
      end else if (op == LOAD || op == STORE) begin
         e = dflt(); e.i_or_d = 1; e.alu_src_b = 2'b01;
         if (op == LOAD) e.mem_read = 1; else e.mem_write = 1;
         repeat (mem_wait) step(0, 0, rb(), rb(), op, e, full_m);
         if (rst_in_mem) begin
            reset_cycle(op);
            return;
         end
         if (op == STORE) e.pc_write = 1;
         step(0, 1, rb(), rb(), op, e, full_m);
         if (op == LOAD) begin
            e = dflt(); e.reg_write = 1; e.wb_sel = 1; e.alu_src_b = 2'b01; e.pc_write = 1;
            step(0, rb(), rb(), rb(), op, e, full_m);
         end
      end
   endtask

   // Monitor: compares whatever the driver has queued for this cycle.
   initial begin
      outs_t act, e, m;
      forever begin
         @(negedge clk);
         act = {mem_read, mem_write, i_or_d, ir_write, alu_out_write, reg_write, pc_write,
                pc_source, wb_sel, alu_src_a, alu_src_b, alu_op, is_halted};
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            m = msk_q.pop_front();
            check($sformatf("cycle%0d_ctrl", cyc), 32'(act & m), 32'(e & m));
            cyc++;
         end
         if (reset === 1'b0 && pc_write === 1'b1) act_retire++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [6:0] ops [9];
      logic [6:0] op;
      full_m = '1;
      strobe_m = '0;
      strobe_m.mem_read = 1; strobe_m.mem_write = 1; strobe_m.ir_write = 1;
      strobe_m.alu_out_write = 1; strobe_m.reg_write = 1; strobe_m.pc_write = 1;
      ops = '{ARITH, ARITH_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL, UNKNOWN};

      reset_cycle(ARITH);
      // Directed sequences
      run_instr(ARITH,  0, 0, 0, 0, 0);
      run_instr(LOAD,   0, 0, 0, 2, 0);
      run_instr(BRANCH, 0, 0, 0, 0, 0);
      run_instr(BRANCH, 1, 0, 0, 0, 0);
      run_instr(JALR,   0, 0, 0, 0, 0);
      run_instr(JAL,    0, 0, 1, 0, 0);
      run_instr(ECALL,  0, 0, 0, 0, 0);
      run_instr(ECALL,  0, 1, 0, 0, 0);
      run_instr(STORE,  0, 0, 0, 0, 1);
      run_instr(UNKNOWN, 0, 0, 0, 0, 0);
      run_instr(STORE,  0, 0, 2, 1, 0);

      // Randomized instruction stream
      for (int i = 0; i < 150; i++) begin
         op = ops[$urandom_range(0, 8)];
         run_instr(op, rb(), ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
                   $urandom_range(0, 3), ($urandom_range(0, 19) == 0));
      end

      repeat (3) @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("retired_pc_writes", 32'(act_retire), 32'(exp_retire));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
